// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the memory port arbiter: default address/data
// widths, the issue-state encoding and the read-return source tag.
// No ports (package).
// ---------------------------------------------------------------------------
package mem_arb_pkg;

   localparam int ADDR_W = 18;
   localparam int DATA_W = 8;
   localparam int CNT_W  = 16;

   // One RAM operation is issued per cycle; IDLE means the port is unused.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_VGA_RD = 2'd1,
      ST_CPU_RD = 2'd2,
      ST_CPU_WR = 2'd3
   } issue_state_t;

   // Identifies who owns a read while it travels through the RAM latency.
   typedef enum logic {
      SRC_VGA = 1'b0,
      SRC_CPU = 1'b1
   } src_tag_t;

   // True for the states that launch a RAM read and therefore expect data back.
   function automatic logic is_read(input issue_state_t st);
      return (st == ST_VGA_RD) || (st == ST_CPU_RD);
   endfunction

   // Maps a read state onto the tag used to steer the returning data.
   function automatic src_tag_t tag_of(input issue_state_t st);
      return (st == ST_CPU_RD) ? SRC_CPU : SRC_VGA;
   endfunction

endpackage

// File: rtl/mem_arb_tag_pipe.sv
// ---------------------------------------------------------------------------
// mem_arb_tag_pipe
// Two-stage tag pipeline that follows each issued read through the RAM.
// Stage 1 is loaded on the edge that issues the read (address on the RAM
// bus), stage 2 one edge later, when the RAM presents its read data.
//
// Ports:
//   clock       in   single clock
//   reset       in   synchronous active-high reset, empties both stages
//   issue_valid in   a read is being issued on this edge
//   issue_tag   in   owner of that read
//   ret_valid   out  read data for the tagged owner is on ram_rdata now
//   ret_tag     out  owner of the returning read
// ---------------------------------------------------------------------------
module mem_arb_tag_pipe
   import mem_arb_pkg::*;
(
   input  logic     clock,
   input  logic     reset,
   input  logic     issue_valid,
   input  src_tag_t issue_tag,
   output logic     ret_valid,
   output src_tag_t ret_tag
);

   logic     s1_valid;
   src_tag_t s1_tag;
   logic     s2_valid;
   src_tag_t s2_tag;

   // Reset empties the pipe so reads in flight never produce a valid pulse.
   always_ff @(posedge clock) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_tag   <= SRC_VGA;
         s2_valid <= 1'b0;
         s2_tag   <= SRC_VGA;
      end else begin
         s1_valid <= issue_valid;
         s1_tag   <= issue_tag;
         s2_valid <= s1_valid;
         s2_tag   <= s1_tag;
      end
   end

   assign ret_valid = s2_valid;
   assign ret_tag   = s2_tag;

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one synchronous result RAM between a VGA scan-out reader and a
// processor. VGA has fixed priority; the processor waits (and the stall
// counter counts) while VGA keeps the port busy.
//
// Ports:
//   clock, reset            single clock, synchronous active-high reset
//   vga_req, vga_addr       VGA read request, sampled every cycle
//   vga_data, vga_valid     VGA read data and its one-cycle valid pulse
//   cpu_req, cpu_we         processor request (level) and write select
//   cpu_addr, cpu_wdata     processor address / write data
//   cpu_gnt                 one-cycle pulse: processor request accepted
//   cpu_rdata, cpu_rvalid   processor read data and its valid pulse
//   ram_addr, ram_wdata     registered RAM address / write data
//   ram_we                  registered RAM write enable
//   ram_rdata               RAM read data, one cycle after ram_addr
//   stall_count             saturating count of cycles the CPU lost to VGA
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_W = mem_arb_pkg::ADDR_W,
   parameter int DATA_W = mem_arb_pkg::DATA_W,
   parameter int CNT_W  = mem_arb_pkg::CNT_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              vga_req,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic [DATA_W-1:0] vga_data,
   output logic              vga_valid,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_rvalid,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [CNT_W-1:0]  stall_count
);

   import mem_arb_pkg::*;

   issue_state_t      state;
   issue_state_t      next_state;
   logic              cpu_eligible;
   logic              stall_hit;
   logic              ret_valid;
   src_tag_t          ret_tag;
   logic [DATA_W-1:0] vga_data_hold;
   logic [DATA_W-1:0] cpu_rdata_hold;

   // A held CPU request is already being served in the cycle its grant is
   // high, so it must not be considered again until the grant drops.
   // VGA always wins; a CPU request that was eligible but lost is a stall.
   always_comb begin
      cpu_eligible = cpu_req && !cpu_gnt;
      stall_hit    = vga_req && cpu_eligible;
      next_state   = ST_IDLE;
      if (vga_req) begin
         next_state = ST_VGA_RD;
      end else if (cpu_eligible) begin
         next_state = cpu_we ? ST_CPU_WR : ST_CPU_RD;
      end
   end

   // Issue register: the decision taken on an edge drives the RAM bus for the
   // whole following cycle. Address and write data are only loaded when a
   // request is issued, so the bus keeps its last values while idle.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_IDLE;
         ram_addr  <= '0;
         ram_wdata <= '0;
         ram_we    <= 1'b0;
      end else begin
         state <= next_state;
         case (next_state)
            ST_VGA_RD: begin
               ram_addr <= vga_addr;
               ram_we   <= 1'b0;
            end
            ST_CPU_RD: begin
               ram_addr <= cpu_addr;
               ram_we   <= 1'b0;
            end
            ST_CPU_WR: begin
               ram_addr  <= cpu_addr;
               ram_wdata <= cpu_wdata;
               ram_we    <= 1'b1;
            end
            default: begin
               ram_we <= 1'b0;
            end
         endcase
      end
   end

   // The grant is simply a decode of the registered issue state, so it is
   // high exactly in the cycle the CPU operation is on the RAM bus.
   assign cpu_gnt = (state == ST_CPU_RD) || (state == ST_CPU_WR);

   // Stall counter sticks at all-ones instead of wrapping back to zero.
   always_ff @(posedge clock) begin
      if (reset) begin
         stall_count <= '0;
      end else if (stall_hit && (stall_count != {CNT_W{1'b1}})) begin
         stall_count <= stall_count + 1'b1;
      end
   end

   // Tags follow reads only; writes never enter the pipe, so they never
   // generate a return pulse.
   mem_arb_tag_pipe u_tag_pipe (
      .clock       (clock),
      .reset       (reset),
      .issue_valid (is_read(next_state)),
      .issue_tag   (tag_of(next_state)),
      .ret_valid   (ret_valid),
      .ret_tag     (ret_tag)
   );

   // Only one tag can be at the head of the pipe, so at most one of the two
   // valid pulses is ever high.
   assign vga_valid  = ret_valid && (ret_tag == SRC_VGA);
   assign cpu_rvalid = ret_valid && (ret_tag == SRC_CPU);

   // The RAM data arrives in the return cycle itself, so it is passed straight
   // through while valid; otherwise the last returned word is shown, which
   // keeps the data outputs stable and zero after reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         vga_data_hold  <= '0;
         cpu_rdata_hold <= '0;
      end else begin
         if (vga_valid) begin
            vga_data_hold <= ram_rdata;
         end
         if (cpu_rvalid) begin
            cpu_rdata_hold <= ram_rdata;
         end
      end
   end

   assign vga_data  = vga_valid  ? ram_rdata : vga_data_hold;
   assign cpu_rdata = cpu_rvalid ? ram_rdata : cpu_rdata_hold;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with a behavioural synchronous RAM.
// RAM is preloaded with mem[a] = a[7:0] ^ 8'h5A, so e.g. mem[0x10] = 8'h4A,
// mem[0x20] = 8'h7A, mem[0x30] = 8'h6A. Expected read data is pushed into
// per-source queues when a read is requested; a monitor pops and compares
// whenever the DUT raises a valid pulse. A second instance with CNT_W=4
// shares the inputs to observe counter saturation.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

   logic        clock;
   logic        reset;
   logic        vga_req;
   logic [17:0] vga_addr;
   logic [7:0]  vga_data;
   logic        vga_valid;
   logic        cpu_req;
   logic        cpu_we;
   logic [17:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_gnt;
   logic [7:0]  cpu_rdata;
   logic        cpu_rvalid;
   logic [17:0] ram_addr;
   logic [7:0]  ram_wdata;
   logic        ram_we;
   logic [7:0]  ram_rdata;
   logic [15:0] stall_count;

   logic [7:0]  small_vga_data;
   logic        small_vga_valid;
   logic        small_cpu_gnt;
   logic [7:0]  small_cpu_rdata;
   logic        small_cpu_rvalid;
   logic [17:0] small_ram_addr;
   logic [7:0]  small_ram_wdata;
   logic        small_ram_we;
   logic [3:0]  small_stall_count;

   logic [7:0]  mem [0:(1<<18)-1];
   logic [7:0]  vga_q [$];
   logic [7:0]  cpu_q [$];
   logic [7:0]  exp_data;

   int n_checks = 0;
   int n_fail   = 0;

   mem_port_arbiter dut (
      .clock       (clock),
      .reset       (reset),
      .vga_req     (vga_req),
      .vga_addr    (vga_addr),
      .vga_data    (vga_data),
      .vga_valid   (vga_valid),
      .cpu_req     (cpu_req),
      .cpu_we      (cpu_we),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_gnt     (cpu_gnt),
      .cpu_rdata   (cpu_rdata),
      .cpu_rvalid  (cpu_rvalid),
      .ram_addr    (ram_addr),
      .ram_wdata   (ram_wdata),
      .ram_we      (ram_we),
      .ram_rdata   (ram_rdata),
      .stall_count (stall_count)
   );

   mem_port_arbiter #(.CNT_W(4)) dut_small (
      .clock       (clock),
      .reset       (reset),
      .vga_req     (vga_req),
      .vga_addr    (vga_addr),
      .vga_data    (small_vga_data),
      .vga_valid   (small_vga_valid),
      .cpu_req     (cpu_req),
      .cpu_we      (cpu_we),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_gnt     (small_cpu_gnt),
      .cpu_rdata   (small_cpu_rdata),
      .cpu_rvalid  (small_cpu_rvalid),
      .ram_addr    (small_ram_addr),
      .ram_wdata   (small_ram_wdata),
      .ram_we      (small_ram_we),
      .ram_rdata   (ram_rdata),
      .stall_count (small_stall_count)
   );

   // 10 ns clock; DUT updates on rising edges, bench works on falling edges.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Synchronous RAM driven by the main instance's port.
   initial begin
      for (int a = 0; a < (1<<18); a++) begin
         mem[a] = 8'(a) ^ 8'h5A;
      end
   end

   always @(posedge clock) begin
      ram_rdata <= mem[ram_addr];
      if (ram_we) begin
         mem[ram_addr] <= ram_wdata;
      end
   end

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic apply_reset();
      reset   = 1'b1;
      vga_req = 1'b0;
      cpu_req = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   // Scoreboard monitor: every valid pulse must match the oldest expectation.
   always @(negedge clock) begin
      if (vga_valid && cpu_rvalid) begin
         check_output("both_valid", 32'd1, 32'd0);
      end
      if (vga_valid) begin
         if (vga_q.size() == 0) begin
            check_output("vga_unexpected_valid", 32'd1, 32'd0);
         end else begin
            exp_data = vga_q.pop_front();
            check_output("vga_data", {24'd0, vga_data}, {24'd0, exp_data});
         end
      end
      if (cpu_rvalid) begin
         if (cpu_q.size() == 0) begin
            check_output("cpu_unexpected_rvalid", 32'd1, 32'd0);
         end else begin
            exp_data = cpu_q.pop_front();
            check_output("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, exp_data});
         end
      end
   end

   initial begin
      reset     = 1'b1;
      vga_req   = 1'b0;
      vga_addr  = '0;
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      $display("[TB] starting");

      // Reset state
      repeat (2) @(negedge clock);
      check_output("rst_ram_addr", 32'(ram_addr), 32'd0);
      check_output("rst_ram_we", 32'(ram_we), 32'd0);
      check_output("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
      check_output("rst_stall", 32'(stall_count), 32'd0);
      reset = 1'b0;

      // VGA read of 0x10
      @(negedge clock);
      vga_req = 1'b1; vga_addr = 18'h00010; vga_q.push_back(8'h4A);
      @(negedge clock);
      check_output("vga_rd_ram_addr", 32'(ram_addr), 32'h10);
      check_output("vga_rd_ram_we", 32'(ram_we), 32'd0);
      vga_req = 1'b0;
      @(negedge clock);
      check_output("vga_rd_valid", 32'(vga_valid), 32'd1);
      check_output("vga_rd_data_n2", 32'(vga_data), 32'h4A);
      @(negedge clock);
      check_output("idle_addr_hold", 32'(ram_addr), 32'h10);
      check_output("vga_valid_pulse", 32'(vga_valid), 32'd0);

      // Simultaneous VGA read 0x30 and CPU read 0x20
      apply_reset();
      @(negedge clock);
      vga_req = 1'b1; vga_addr = 18'h00030; vga_q.push_back(8'h6A);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h00020; cpu_q.push_back(8'h7A);
      @(negedge clock);
      check_output("sim_vga_addr", 32'(ram_addr), 32'h30);
      check_output("sim_no_gnt", 32'(cpu_gnt), 32'd0);
      check_output("sim_stall", 32'(stall_count), 32'd1);
      vga_req = 1'b0;
      @(negedge clock);
      check_output("sim_gnt", 32'(cpu_gnt), 32'd1);
      check_output("sim_cpu_addr", 32'(ram_addr), 32'h20);
      check_output("sim_vga_valid", 32'(vga_valid), 32'd1);
      cpu_req = 1'b0;
      @(negedge clock);
      check_output("sim_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
      check_output("sim_gnt_pulse", 32'(cpu_gnt), 32'd0);
      check_output("sim_stall_hold", 32'(stall_count), 32'd1);

      // CPU write 0xA5 to 0x3FFFF, then read it back
      @(negedge clock);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 18'h3FFFF; cpu_wdata = 8'hA5;
      @(negedge clock);
      check_output("wr_ram_we", 32'(ram_we), 32'd1);
      check_output("wr_ram_addr", 32'(ram_addr), 32'h3FFFF);
      check_output("wr_ram_wdata", 32'(ram_wdata), 32'hA5);
      check_output("wr_gnt", 32'(cpu_gnt), 32'd1);
      cpu_we = 1'b0; cpu_wdata = 8'h00; cpu_q.push_back(8'hA5);
      @(negedge clock);
      check_output("wr_we_pulse", 32'(ram_we), 32'd0);
      check_output("wr_no_reissue", 32'(cpu_gnt), 32'd0);
      check_output("wr_no_rvalid", 32'(cpu_rvalid), 32'd0);
      check_output("wr_wdata_hold", 32'(ram_wdata), 32'hA5);
      @(negedge clock);
      check_output("rd_gnt", 32'(cpu_gnt), 32'd1);
      check_output("rd_ram_we", 32'(ram_we), 32'd0);
      cpu_req = 1'b0;
      @(negedge clock);
      check_output("rd_rvalid", 32'(cpu_rvalid), 32'd1);

      // VGA saturation: 20 cycles of VGA with a CPU read held
      apply_reset();
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (i > 0) begin
            check_output("sat_no_gnt", 32'(cpu_gnt), 32'd0);
         end
         vga_req = 1'b1; vga_addr = 18'h00100 + 18'(i);
         vga_q.push_back(8'(i) ^ 8'h5A);
         cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h00020;
      end
      @(negedge clock);
      vga_req = 1'b0;
      check_output("sat_no_gnt_last", 32'(cpu_gnt), 32'd0);
      check_output("sat_stall_20", 32'(stall_count), 32'd20);
      check_output("sat_small_15", 32'(small_stall_count), 32'd15);
      cpu_q.push_back(8'h7A);
      @(negedge clock);
      check_output("sat_gnt_free", 32'(cpu_gnt), 32'd1);
      check_output("sat_stall_hold", 32'(stall_count), 32'd20);
      check_output("sat_small_hold", 32'(small_stall_count), 32'd15);
      cpu_req = 1'b0;
      for (int i = 0; i < 20 && (vga_q.size() != 0 || cpu_q.size() != 0); i++) begin
         @(negedge clock);
      end

      // Reset mid-read: VGA read of 0x40 discarded by reset
      @(negedge clock);
      vga_req = 1'b1; vga_addr = 18'h00040;
      @(negedge clock);
      vga_req = 1'b0; reset = 1'b1;
      @(negedge clock);
      check_output("mid_rst_vga_valid", 32'(vga_valid), 32'd0);
      check_output("mid_rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
      check_output("mid_rst_vga_data", 32'(vga_data), 32'd0);
      check_output("mid_rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
      check_output("mid_rst_ram_addr", 32'(ram_addr), 32'd0);
      check_output("mid_rst_ram_wdata", 32'(ram_wdata), 32'd0);
      check_output("mid_rst_ram_we", 32'(ram_we), 32'd0);
      check_output("mid_rst_gnt", 32'(cpu_gnt), 32'd0);
      check_output("mid_rst_stall", 32'(stall_count), 32'd0);
      reset = 1'b0;
      repeat (4) @(negedge clock);

      // Drain: every expected read must have come back
      for (int i = 0; i < 50 && (vga_q.size() != 0 || cpu_q.size() != 0); i++) begin
         @(negedge clock);
      end
      check_output("vga_q_empty", 32'(vga_q.size()), 32'd0);
      check_output("cpu_q_empty", 32'(cpu_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 18, RAM address width; DATA_W, default 8, pixel width; CNT_W, default 16, stall counter width.
REQ-002 SHALL have port: clock  input  1  single clock for all logic.
REQ-003 SHALL have port: reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: vga_req  input  1  VGA read request, sampled each cycle.
REQ-005 SHALL have port: vga_addr  input  ADDR_W  VGA read address.
REQ-006 SHALL have port: vga_data  output  DATA_W  VGA read data.
REQ-007 SHALL have port: vga_valid  output  1  vga_data valid, one-cycle pulse.
REQ-008 SHALL have port: cpu_req  input  1  processor request, level, held until granted.
REQ-009 SHALL have port: cpu_we  input  1  processor write when 1, read when 0.
REQ-010 SHALL have port: cpu_addr  input  ADDR_W  processor address.
REQ-011 SHALL have port: cpu_wdata  input  DATA_W  processor write data.
REQ-012 SHALL have port: cpu_gnt  output  1  request accepted, one-cycle pulse.
REQ-013 SHALL have port: cpu_rdata  output  DATA_W  processor read data.
REQ-014 SHALL have port: cpu_rvalid  output  1  cpu_rdata valid, one-cycle pulse.
REQ-015 SHALL have port: ram_addr  output  ADDR_W  shared result-RAM address, registered.
REQ-016 SHALL have port: ram_wdata  output  DATA_W  RAM write data, registered.
REQ-017 SHALL have port: ram_we  output  1  RAM write enable, registered.
REQ-018 SHALL have port: ram_rdata  input  DATA_W  RAM read data, one cycle after ram_addr.
REQ-019 SHALL have port: stall_count  output  CNT_W  saturating count of cycles a pending CPU request lost to VGA.

Function
REQ-020 SHALL decide once per cycle among issue states IDLE, VGA_RD, CPU_RD, CPU_WR, held in a registered state.
REQ-021 SHALL apply fixed priority: vga_req beats an eligible cpu_req in the same cycle.
REQ-022 SHALL treat cpu_req as eligible only when cpu_gnt is low in that cycle, so one held request is never issued twice.
REQ-023 SHALL, for a request sampled at edge N, drive ram_addr, ram_we and ram_wdata from that request during cycle N+1.
REQ-024 SHALL assert cpu_gnt during cycle N+1 for every CPU read or write issued.
REQ-025 SHALL drive ram_we=1 only in CPU_WR, with ram_wdata=cpu_wdata; ram_we=0 otherwise.
REQ-026 SHALL hold ram_addr and ram_wdata at their last values in IDLE.
REQ-027 SHALL track each issued read with a source tag (VGA or CPU) through a 2-stage pipeline.
REQ-028 SHALL return read data in cycle N+2: vga_data=ram_rdata with vga_valid=1, or cpu_rdata=ram_rdata with cpu_rvalid=1, according to the tag.
REQ-029 SHALL never assert vga_valid and cpu_rvalid in the same cycle.
REQ-030 SHALL produce no rvalid pulse for writes.
REQ-031 SHALL sustain vga_req on every cycle, issuing a VGA read on every cycle, while CPU requests wait.
REQ-032 SHALL increment stall_count by 1 in each cycle an eligible cpu_req loses to vga_req, saturating at all-ones.
REQ-033 SHALL preserve request order; a CPU read following a CPU write to the same address returns the written data.

Reset
REQ-034 SHALL, on a clock edge with reset=1, set state=IDLE, ram_addr=0, ram_wdata=0, ram_we=0, cpu_gnt=0, vga_valid=0, cpu_rvalid=0, vga_data=0, cpu_rdata=0, stall_count=0, and clear the tag pipeline.
REQ-035 SHALL, when reset is asserted mid-operation, discard all in-flight reads; no valid pulse follows for them.
REQ-036 SHALL ignore requests sampled while reset=1.

Structure
REQ-037 SHALL take ADDR_W, DATA_W, the issue-state enum and the source-tag enum from shared package mem_arb_pkg.
REQ-038 SHALL implement the read-return tag pipeline as sub-module mem_arb_tag_pipe.

Verification
REQ-039 SHALL cover VGA read: vga_req=1, vga_addr=0x00010 at edge N -> ram_addr=0x00010 at N+1; vga_valid=1 with vga_data=RAM[0x10] at N+2.
REQ-040 SHALL cover simultaneous requests: vga_req and CPU read of 0x00020 at edge N -> VGA issued at N+1; cpu_gnt at N+2; cpu_rvalid at N+3; stall_count=1.
REQ-041 SHALL cover write then read: CPU write 0xA5 to 0x3FFFF, then read of 0x3FFFF -> ram_we=1 for one cycle; cpu_rdata=0xA5; no rvalid for the write.
REQ-042 SHALL cover VGA saturation: vga_req held for 20 cycles with cpu_req held -> no cpu_gnt for 20 cycles; stall_count=20; grant on the first free cycle.
REQ-043 SHALL cover reset mid-read: reset at N+1 after a read at N -> no valid pulse; all outputs zero at N+2.
REQ-044 SHALL cover counter saturation: with CNT_W=4, 20 stall cycles -> stall_count stays 15.
